// File: rtl/muldiv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_pkg                                              |
// | Description : Shared op/state encodings and latency defaults for      |
// |               the HI/LO multiply-divide controller.                   |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
package muldiv_pkg;

    localparam int c_DEF_MULT_CYCLES = 5;
    localparam int c_DEF_DIV_CYCLES  = 10;

    localparam logic [2:0] c_MD_MULT  = 3'd0;
    localparam logic [2:0] c_MD_MULTU = 3'd1;
    localparam logic [2:0] c_MD_DIV   = 3'd2;
    localparam logic [2:0] c_MD_DIVU  = 3'd3;
    localparam logic [2:0] c_MD_MTHI  = 3'd4;
    localparam logic [2:0] c_MD_MTLO  = 3'd5;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_MUL  = 2'd1;
    localparam logic [1:0] c_ST_DIV  = 2'd2;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } mdResult_t;

    // Ops that occupy the unit for multiple cycles (mult/multu/div/divu).
    function automatic logic isIterative(input logic [2:0] op);
        return op <= c_MD_DIVU;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_arith.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_arith                                            |
// | Description : Combinational signed/unsigned multiply and divide with  |
// |               divide-by-zero detection and INT_MIN/-1 handling.       |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module muldiv_arith
    import muldiv_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [31:0] i_srcA,
    input  logic [31:0] i_srcB,
    output mdResult_t   o_result,
    output logic        o_divZero
);

    logic [63:0] w_prodS;
    logic [63:0] w_prodU;
    logic        w_isDiv;
    logic        w_signedDiv;
    logic        w_negA;
    logic        w_negB;
    logic [31:0] w_magA;
    logic [31:0] w_magB;
    logic [31:0] w_safeB;
    logic [31:0] w_magQ;
    logic [31:0] w_magR;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic        w_overflow;

    assign w_prodS = {{32{i_srcA[31]}}, i_srcA} * {{32{i_srcB[31]}}, i_srcB};
    assign w_prodU = {32'd0, i_srcA} * {32'd0, i_srcB};

    // Signed divide is done on magnitudes so truncation is toward zero.
    assign w_isDiv     = (i_op == c_MD_DIV) || (i_op == c_MD_DIVU);
    assign w_signedDiv = (i_op == c_MD_DIV);
    assign w_negA      = w_signedDiv & i_srcA[31];
    assign w_negB      = w_signedDiv & i_srcB[31];
    assign w_magA      = w_negA ? (32'd0 - i_srcA) : i_srcA;
    assign w_magB      = w_negB ? (32'd0 - i_srcB) : i_srcB;
    assign w_safeB     = (w_magB == 32'd0) ? 32'd1 : w_magB;
    assign w_magQ      = w_magA / w_safeB;
    assign w_magR      = w_magA % w_safeB;
    assign w_quot      = (w_negA ^ w_negB) ? (32'd0 - w_magQ) : w_magQ;
    assign w_rem       = w_negA ? (32'd0 - w_magR) : w_magR;
    assign w_overflow  = w_signedDiv && (i_srcA == 32'h8000_0000) && (i_srcB == 32'hFFFF_FFFF);

    assign o_divZero = w_isDiv && (i_srcB == 32'd0);

    always_comb begin : p_select
        o_result = '0;
        case (i_op)
            c_MD_MULT:  o_result = w_prodS;
            c_MD_MULTU: o_result = w_prodU;
            c_MD_DIV, c_MD_DIVU: begin
                if (w_overflow) begin
                    o_result.hi = 32'd0;
                    o_result.lo = 32'h8000_0000;
                end else begin
                    o_result.hi = w_rem;
                    o_result.lo = w_quot;
                end
            end
            default: o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : muldiv_ctrl                                             |
// | Description : HI/LO multiply-divide controller with fixed-latency     |
// |               busy window and pipeline stall request.                 |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = c_DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = c_DEF_DIV_CYCLES
)(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        md_use_d,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE   = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_pendHi;
    logic [31:0]        r_pendLo;

    logic [1:0]         w_nextState;
    logic [c_CNT_W-1:0] w_nextCnt;
    logic               w_launch;
    logic               w_commit;
    logic               w_writeHi;
    logic               w_writeLo;
    mdResult_t          w_arithRes;
    logic               w_divZero;

    muldiv_arith u_arith (
        .i_op      (op),
        .i_srcA    (src_a),
        .i_srcB    (src_b),
        .o_result  (w_arithRes),
        .o_divZero (w_divZero)
    );

    always_ff @(posedge clk or posedge reset) begin : p_stateReg
        if (reset) begin
            r_state  <= c_ST_IDLE;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_pendHi <= '0;
            r_pendLo <= '0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            // A zero divisor re-latches the current HI/LO so the commit is a no-op.
            if (w_launch) begin
                if (w_divZero) begin
                    r_pendHi <= r_hi;
                    r_pendLo <= r_lo;
                end else begin
                    r_pendHi <= w_arithRes.hi;
                    r_pendLo <= w_arithRes.lo;
                end
            end
            if (w_commit) begin
                r_hi <= r_pendHi;
                r_lo <= r_pendLo;
            end else begin
                if (w_writeHi) r_hi <= src_a;
                if (w_writeLo) r_lo <= src_a;
            end
        end
    end

    always_comb begin : p_nextState
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_launch    = 1'b0;
        w_commit    = 1'b0;
        w_writeHi   = 1'b0;
        w_writeLo   = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    case (op)
                        c_MD_MULT, c_MD_MULTU: begin
                            w_nextState = c_ST_MUL;
                            w_nextCnt   = c_MULT_LOAD;
                            w_launch    = 1'b1;
                        end
                        c_MD_DIV, c_MD_DIVU: begin
                            w_nextState = c_ST_DIV;
                            w_nextCnt   = c_DIV_LOAD;
                            w_launch    = 1'b1;
                        end
                        c_MD_MTHI: w_writeHi = 1'b1;
                        c_MD_MTLO: w_writeLo = 1'b1;
                        default: ;
                    endcase
                end
            end
            c_ST_MUL, c_ST_DIV: begin
                if (r_cnt <= c_CNT_ONE) begin
                    w_nextState = c_ST_IDLE;
                    w_nextCnt   = '0;
                    w_commit    = 1'b1;
                end else begin
                    w_nextCnt = r_cnt - c_CNT_ONE;
                end
            end
            default: begin
                w_nextState = c_ST_IDLE;
                w_nextCnt   = '0;
            end
        endcase
    end

    always_comb begin : p_outputs
        busy     = (r_state != c_ST_IDLE);
        md_stall = ~reset & md_use_d & (busy | (start & isIterative(op)));
        hi       = r_hi;
        lo       = r_lo;
    end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | Module      : tb_muldiv_ctrl                                          |
// | Description : Table-driven bench with HI/LO scoreboard for muldiv.    |
// | Revision    : 1.0                                                     |
// +----------------------------------------------------------------------+
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        md_use_d;
    logic        busy;
    logic        md_stall;
    logic [31:0] hi;
    logic [31:0] lo;

    always #5 clk = ~clk;

    muldiv_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .md_use_d (md_use_d),
        .busy     (busy),
        .md_stall (md_stall),
        .hi       (hi),
        .lo       (lo)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          busyN;
        logic [31:0] expHi;
        logic [31:0] expLo;
    } vec_t;

    int          nPass = 0;
    int          nTotal = 0;
    logic [63:0] expQ[$];
    logic [31:0] mHi = 32'd0;
    logic [31:0] mLo = 32'd0;
    vec_t        vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    task automatic drive(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
    endtask

    // Counts busy cycles at negedges until busy drops, bounded.
    task automatic waitIdle(output int n, output logic holdOk, output int stallN);
        n = 0;
        holdOk = 1'b1;
        stallN = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) break;
            n++;
            if (md_stall) stallN++;
            if ({hi, lo} !== {mHi, mLo}) holdOk = 1'b0;
        end
    endtask

    task automatic runVec(input vec_t v, input int idx);
        int          n;
        int          sn;
        logic        holdOk;
        logic [63:0] exp;
        @(negedge clk);
        drive(v.op, v.a, v.b);
        expQ.push_back({v.expHi, v.expLo});
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle(n, holdOk, sn);
        check($sformatf("vec%0d busy", idx), 64'(n), 64'(v.busyN));
        if (v.busyN > 0) check($sformatf("vec%0d hold", idx), {63'd0, holdOk}, 64'd1);
        exp = expQ.pop_front();
        check($sformatf("vec%0d hilo", idx), {hi, lo}, exp);
        mHi = exp[63:32];
        mLo = exp[31:0];
    endtask

    initial begin
        int          n;
        int          sn;
        logic        holdOk;
        logic        cleanOk;
        logic [63:0] exp;

        vecs[0]  = '{c_MD_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
        vecs[1]  = '{c_MD_MULTU, 32'hFFFFFFFE, 32'd3,        5,  32'h00000002, 32'hFFFFFFFA};
        vecs[2]  = '{c_MD_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3]  = '{c_MD_DIVU,  32'd7,        32'd0,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[4]  = '{c_MD_DIV,   32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
        vecs[5]  = '{c_MD_MTHI,  32'h12345678, 32'd0,        0,  32'h12345678, 32'h80000000};
        vecs[6]  = '{c_MD_MTLO,  32'hCAFEBABE, 32'd0,        0,  32'h12345678, 32'hCAFEBABE};
        vecs[7]  = '{3'd6,       32'hFFFFFFFF, 32'd5,        0,  32'h12345678, 32'hCAFEBABE};
        vecs[8]  = '{c_MD_DIVU,  32'd100,      32'd7,        10, 32'h00000002, 32'h0000000E};
        vecs[9]  = '{c_MD_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD};
        vecs[10] = '{c_MD_MULT,  32'h7FFFFFFF, 32'h7FFFFFFF, 5,  32'h3FFFFFFF, 32'h00000001};
        vecs[11] = '{c_MD_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
        vecs[12] = '{c_MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
        vecs[13] = '{c_MD_DIV,   32'd0,        32'd0,        10, 32'hFFFFFFFE, 32'h00000001};
        vecs[14] = '{3'd7,       32'h00000001, 32'd1,        0,  32'hFFFFFFFE, 32'h00000001};

        // Reset state, with a would-be stall request pending.
        reset = 1'b1;
        md_use_d = 1'b1;
        drive(c_MD_MULT, 32'd1, 32'd1);
        #1;
        check("reset stall", {63'd0, md_stall}, 64'd0);
        check("reset busy", {63'd0, busy}, 64'd0);
        check("reset hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        md_use_d = 1'b0;

        foreach (vecs[i]) runVec(vecs[i], i);

        // Stall window: start cycle plus every busy cycle.
        @(negedge clk);
        md_use_d = 1'b1;
        drive(c_MD_MULT, 32'd5, 32'd6);
        expQ.push_back({32'd0, 32'd30});
        #1 check("stall start", {63'd0, md_stall}, 64'd1);
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle(n, holdOk, sn);
        check("stall busyN", 64'(sn), 64'd5);
        check("stall after", {63'd0, md_stall}, 64'd0);
        exp = expQ.pop_front();
        check("stall hilo", {hi, lo}, exp);
        drive(c_MD_MTHI, 32'h0BADF00D, 32'd0);
        #1 check("mthi nostall", {63'd0, md_stall}, 64'd0);
        @(posedge clk);
        #1 start = 1'b0;
        md_use_d = 1'b0;
        @(negedge clk);
        check("mthi busy", {63'd0, busy}, 64'd0);
        check("mthi hi", {32'd0, hi}, {32'd0, 32'h0BADF00D});
        mHi = 32'h0BADF00D;
        mLo = 32'd30;

        // Back-to-back mult issued on the cycle busy falls.
        drive(c_MD_MULT, 32'd3, 32'd4);
        expQ.push_back({32'd0, 32'd12});
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle(n, holdOk, sn);
        exp = expQ.pop_front();
        check("b2b first", {hi, lo}, exp);
        mHi = exp[63:32];
        mLo = exp[31:0];
        drive(c_MD_MULT, 32'hFFFFFFFF, 32'd2);
        expQ.push_back({32'hFFFFFFFF, 32'hFFFFFFFE});
        @(posedge clk);
        #1 start = 1'b0;
        waitIdle(n, holdOk, sn);
        check("b2b busy", 64'(n), 64'd5);
        check("b2b hold", {63'd0, holdOk}, 64'd1);
        exp = expQ.pop_front();
        check("b2b second", {hi, lo}, exp);

        // Reset in busy cycle 3 of a div abandons the result.
        @(negedge clk);
        drive(c_MD_DIV, 32'd100, 32'd3);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("rst busy", {63'd0, busy}, 64'd0);
        check("rst hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        cleanOk = 1'b1;
        repeat (15) begin
            @(negedge clk);
            if (busy || ({hi, lo} !== 64'd0)) cleanOk = 1'b0;
        end
        check("rst nocommit", {63'd0, cleanOk}, 64'd1);

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The module SHALL have parameter MULT_CYCLES, default 5, giving the number of busy cycles for mult/multu.
REQ-002 The module SHALL have parameter DIV_CYCLES, default 10, giving the number of busy cycles for div/divu.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1 bit: the E-stage instruction is a muldiv op; valid for one cycle.
REQ-006 The module SHALL have port op, input, 3 bits: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6-7 no-op.
REQ-007 The module SHALL have port src_a, input, 32 bits: forwarded rs value (dividend, multiplicand, or mthi/mtlo data).
REQ-008 The module SHALL have port src_b, input, 32 bits: forwarded rt value (divisor or multiplier).
REQ-009 The module SHALL have port md_use_d, input, 1 bit: the D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo.
REQ-010 The module SHALL have port busy, output, 1 bit: an iterative operation is in progress.
REQ-011 The module SHALL have port md_stall, output, 1 bit: the pipeline stall request, combinational.
REQ-012 The module SHALL have port hi, output, 32 bits: the architectural HI register.
REQ-013 The module SHALL have port lo, output, 32 bits: the architectural LO register.

Function
REQ-014 The controller SHALL have exactly three states: IDLE, MUL and DIV, plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 In IDLE, start with op 0/1 SHALL compute the product, latch it into pend_hi/pend_lo, load cnt with MULT_CYCLES and enter MUL.
REQ-016 In IDLE, start with op 2/3 SHALL compute the quotient/remainder, latch them into pend_hi/pend_lo, load cnt with DIV_CYCLES and enter DIV.
REQ-017 In IDLE, start with op 4 or 5 SHALL write src_a to hi or lo at that edge and stay in IDLE; busy SHALL stay low.
REQ-018 In IDLE, start with op 6/7 SHALL have no effect.
REQ-019 busy SHALL be high for exactly N cycles, starting the cycle after the start cycle (N = MULT_CYCLES or DIV_CYCLES).
REQ-020 On the edge ending the last busy cycle, hi/lo SHALL take pend_hi/pend_lo and the state SHALL return to IDLE.
REQ-021 Updated hi/lo SHALL be visible in the first cycle busy is low.
REQ-022 Until the result is committed, hi/lo SHALL hold their previous values.
REQ-023 start while busy SHALL be ignored, since the pipeline guarantees it does not occur while md_stall is high.
REQ-024 md_stall SHALL equal md_use_d & (busy | (start & op<=3)).
REQ-025 Multiply results SHALL form a 64-bit product with HI = bits 63:32 and LO = bits 31:0; mult is signed and multu is unsigned.
REQ-026 Divide results SHALL put the quotient in LO and the remainder in HI.
REQ-027 Signed divide SHALL truncate toward zero, with the remainder taking the sign of the dividend.
REQ-028 Signed divide 0x80000000 / 0xFFFFFFFF SHALL give LO = 0x80000000 and HI = 0.
REQ-029 Divide by zero SHALL still run DIV_CYCLES busy cycles and leave HI/LO unchanged.
REQ-030 A cycle in which busy falls and a new start arrives SHALL accept the new op normally, because IDLE is already reached.

Reset
REQ-031 Reset SHALL asynchronously force the state to IDLE and clear cnt, hi, lo, pend_hi and pend_lo to 0.
REQ-032 Reset SHALL force busy to 0.
REQ-033 Reset mid-operation SHALL abandon the pending result; no commit SHALL occur after reset is released.
REQ-034 md_stall SHALL be 0 while reset is high.

Structure
REQ-035 The op encodings (MD_MULT..MD_MTLO) and the state encodings SHALL live in a shared package, muldiv_pkg, used by the decoder/controller.
REQ-036 The default latency constants SHALL also live in muldiv_pkg.
REQ-037 One sub-module, muldiv_arith, SHALL hold the combinational signed/unsigned multiply and divide, including the zero and overflow special cases.
REQ-038 The state machine, counter, pending registers and HI/LO registers SHALL be in muldiv_ctrl.

Verification
REQ-039 mult with src_a=0xFFFFFFFE (-2) and src_b=3: busy SHALL be high for 5 cycles, then HI=0xFFFFFFFF and LO=0xFFFFFFFA; multu on the same operands SHALL give HI=0x00000002 and LO=0xFFFFFFFA.
REQ-040 div with src_a=-7 and src_b=2: busy SHALL be high for 10 cycles, then LO=0xFFFFFFFD and HI=0xFFFFFFFF; divu 7/0 SHALL leave HI/LO unchanged after 10 busy cycles.
REQ-041 mthi 0x12345678 while IDLE SHALL give hi=0x12345678 the next cycle with no busy; md_use_d=1 held during a mult SHALL give md_stall high in the start cycle plus 5 busy cycles, then low.
REQ-042 Assert reset at busy cycle 3 of a div: busy SHALL drop immediately, hi/lo SHALL read 0, and no commit SHALL occur afterwards.
REQ-043 A second mult issued in the cycle busy first falls SHALL be accepted, give 5 more busy cycles, and commit the second result.
REQ-044 Signed div 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0.
